seq_mult_arbiter: RTL and testbench

//  Shares one sequential 32x32 signed multiplier (start-by-reset type: operands load while its

---
 rtl/seq_mult_arbiter.sv | 156 +++++++++++++++
 tb/tb_seq_mult_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: round-robin front end that shares one start-by-reset
// sequential signed multiplier among NREQ requesters, one operation at a time.
//
// Handshake rule for both sides: a transfer happens on the rising edge where
// valid and ready are both high. Requesters hold valid and operands stable
// until that edge. The arbiter holds resp_valid and its payload stable until
// resp_ready is seen.
module seq_mult_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = 32,
    parameter  int TIMEOUT = 80,
    localparam int IDW     = $clog2(NREQ),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_p,
    output logic                    resp_err,
    output logic                    mult_rst,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic [2*WIDTH-1:0]      mult_p,
    input  logic                    mult_rdy,
    output logic [1:0]              dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     rr_q;
    logic [TW-1:0]      timer_q;
    logic               mult_rst_q;
    logic [WIDTH-1:0]   mult_a_q, mult_b_q;
    logic [IDW-1:0]     resp_id_q;
    logic [2*WIDTH-1:0] resp_p_q;
    logic               resp_err_q;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic               timer_done;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    assign timer_done = (timer_q == TW'(TIMEOUT - 1));

    // Round-robin search starting one past the last winner.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(rr_q) + k) % NREQ;
            idx_w = IDW'(idx);
            if (!grant_found && req_valid[idx_w]) begin
                grant_found = 1'b1;
                grant_idx   = idx_w;
            end
        end
    end

    // Accept is offered only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found && !reset) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Next-state logic for IDLE -> LOAD -> RUN -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (mult_rdy || timer_done) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand, timer and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= IDW'(NREQ - 1);
            timer_q    <= '0;
            mult_rst_q <= 1'b1;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            resp_id_q  <= '0;
            resp_p_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        mult_a_q  <= a_arr[grant_idx];
                        mult_b_q  <= b_arr[grant_idx];
                        resp_id_q <= grant_idx;
                        rr_q      <= grant_idx;
                    end
                end
                S_LOAD: begin
                    // Multiplier has just sampled the operands; release it.
                    mult_rst_q <= 1'b0;
                    timer_q    <= '0;
                end
                S_RUN: begin
                    if (mult_rdy) begin
                        resp_p_q   <= mult_p;
                        resp_err_q <= 1'b0;
                    end else if (timer_done) begin
                        resp_p_q   <= '0;
                        resp_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) mult_rst_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = resp_id_q;
    assign resp_p      = resp_p_q;
    assign resp_err    = resp_err_q;
    assign mult_rst    = mult_rst_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Bench for seq_mult_arbiter: behavioural start-by-reset multiplier, a
// round-robin/arithmetic reference model with a scoreboard queue, and a
// directed sequence of scenarios.
module tb_seq_mult_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  localparam int TIMEOUT = 80;
  localparam int IDW = 2;
  localparam int PW = 2 * WIDTH;
  localparam int EW = IDW + PW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_err, mult_rst, mult_rdy;
  logic [IDW-1:0] resp_id;
  logic [PW-1:0] resp_p, mult_p;
  logic [WIDTH-1:0] mult_a, mult_b;
  logic [1:0] dbg_state;

  seq_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_p(resp_p), .resp_err(resp_err),
    .mult_rst(mult_rst), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .mult_rdy(mult_rdy), .dbg_state_o(dbg_state)
  );

  // behavioural multiplier: loads while mult_rst high, rdy 2*WIDTH+1 edges after release
  logic stub_dead = 1'b0;
  logic [WIDTH-1:0] ma_s, mb_s;
  int mcnt;
  logic mrdy_q;
  always @(posedge clk) begin
    if (mult_rst) begin
      ma_s <= mult_a;
      mb_s <= mult_b;
      mcnt <= 0;
      mrdy_q <= 1'b0;
    end else if (mcnt != PW) begin
      mcnt <= mcnt + 1;
    end else begin
      mrdy_q <= 1'b1;
    end
  end
  assign mult_rdy = mrdy_q & ~stub_dead;
  assign mult_p = exp_prod(ma_s, mb_s);

  // scoreboard and counters
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_resp = '0;
  logic [EW-1:0] exp_e;
  int accepts[$];
  int model_ptr = NREQ - 1;
  logic model_busy = 1'b0;
  logic lat_done = 1'b0;
  int accept_cycle = 0;
  int exp_lat = 0;
  int mon_g;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = {{WIDTH{a[WIDTH-1]}}, a};
    sb = {{WIDTH{b[WIDTH-1]}}, b};
    return sa * sb;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // reference model: checks grants, pushes expected results, pops on response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (model_busy) begin
        check("req_ready_while_busy", EW'(req_ready), EW'(0));
        if (resp_valid) begin
          if (!lat_done) begin
            check("resp_latency", EW'(cycle - accept_cycle), EW'(exp_lat));
            lat_done = 1'b1;
          end
          if (resp_ready) begin
            check("scoreboard_nonempty", EW'(exp_q.size() != 0), EW'(1));
            if (exp_q.size() != 0) begin
              exp_e = exp_q.pop_front();
              check("resp_payload", {resp_id, resp_p, resp_err}, exp_e);
            end
            last_resp = {resp_id, resp_p, resp_err};
            model_busy = 1'b0;
          end
        end
      end else begin
        check("resp_valid_when_idle", EW'(resp_valid), EW'(0));
        mon_g = exp_grant(req_valid, model_ptr);
        check("req_ready_grant", EW'(req_ready), (mon_g < 0) ? EW'(0) : (EW'(1) << mon_g));
        if (mon_g >= 0) begin
          exp_q.push_back({IDW'(mon_g),
                           stub_dead ? PW'(0) : exp_prod(req_a[mon_g*WIDTH +: WIDTH], req_b[mon_g*WIDTH +: WIDTH]),
                           stub_dead});
          model_ptr = mon_g;
          model_busy = 1'b1;
          lat_done = 1'b0;
          accept_cycle = cycle + 1;
          exp_lat = stub_dead ? TIMEOUT + 1 : 2 * WIDTH + 3;
          accepts.push_back(mon_g);
        end
      end
    end
  end

  // driver tasks
  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(input int i, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[i] && req_ready[i]) && n < 300);
    check({tag, "_accept"}, EW'(req_valid[i] && req_ready[i]), EW'(1));
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((model_busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_in_budget"}, EW'(n < budget), EW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, EW'(req_ready), EW'(0));
    check({tag, "_resp_valid"}, EW'(resp_valid), EW'(0));
    check({tag, "_resp_err"}, EW'(resp_err), EW'(0));
    check({tag, "_resp_id"}, EW'(resp_id), EW'(0));
    check({tag, "_resp_p"}, EW'(resp_p), EW'(0));
    check({tag, "_mult_a"}, EW'(mult_a), EW'(0));
    check({tag, "_mult_b"}, EW'(mult_b), EW'(0));
    check({tag, "_mult_rst"}, EW'(mult_rst), EW'(1));
    check({tag, "_state"}, EW'(dbg_state), EW'(0));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int n;
  int ri;
  logic [WIDTH-1:0] ra, rb;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_mult_rst", EW'(mult_rst), EW'(1));

    // all four requesters valid continuously: order 0,1,2,3,0
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i + 2), WIDTH'(32'hFFFF_FFF0 + i));
    n = 0;
    while (accepts.size() < 5 && n < 800) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = '0;
    check("rr_five_accepts", EW'(accepts.size() >= 5), EW'(1));
    wait_idle("rr", 200);
    for (int k = 0; k < 5; k++) begin
      if (k < accepts.size()) check($sformatf("rr_order_%0d", k), EW'(accepts[k]), EW'(exp_order[k]));
    end

    // single request from requester 0: 3*5
    set_req(0, 32'd3, 32'd5);
    wait_accept(0, "t1");
    wait_idle("t1", 200);
    check("t1_result", last_resp, {2'd0, 64'd15, 1'b0});

    // negative operand from requester 2
    set_req(2, 32'hFFFF_FFFE, 32'd7);
    wait_accept(2, "t2");
    wait_idle("t2", 200);
    check("t2_result", last_resp, {2'd2, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0});

    // backpressure in RESP for 10 cycles with another requester waiting
    resp_ready = 1'b0;
    set_req(3, 32'd100, 32'hFFFF_FFFE);
    wait_accept(3, "t4");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 200);
    check("t4_resp_seen", EW'(resp_valid), EW'(1));
    @(posedge clk);
    #1 set_req(1, 32'd11, 32'd13);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_hold_valid", EW'(resp_valid), EW'(1));
      check("t4_hold_id", EW'(resp_id), EW'(3));
      check("t4_hold_p", EW'(resp_p), EW'(64'hFFFF_FFFF_FFFF_FF38));
      check("t4_hold_req_ready", EW'(req_ready), EW'(0));
      check("t4_hold_mult_rst", EW'(mult_rst), EW'(0));
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_accept(1, "t4b");
    wait_idle("t4b", 200);
    check("t4b_result", last_resp, {2'd1, 64'd143, 1'b0});

    // reset pulse in RUN drops the operation
    set_req(0, 32'd9, 32'd9);
    wait_accept(0, "t5");
    repeat (22) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_busy = 1'b0;
    model_ptr = NREQ - 1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (80) @(posedge clk);
    #1 set_req(1, 32'd6, 32'hFFFF_FFFD);
    wait_accept(1, "t5b");
    wait_idle("t5b", 200);
    check("t5_result", last_resp, {2'd1, 64'hFFFF_FFFF_FFFF_FFEE, 1'b0});

    // dead multiplier: timeout completion with error
    stub_dead = 1'b1;
    set_req(2, 32'd5, 32'd5);
    wait_accept(2, "t6");
    wait_idle("t6", 200);
    check("t6_result", last_resp, {2'd2, 64'd0, 1'b1});
    stub_dead = 1'b0;

    // random operands from random requesters
    for (int r = 0; r < 4; r++) begin
      ri = $urandom_range(0, NREQ - 1);
      ra = $urandom;
      rb = $urandom;
      set_req(ri, ra, rb);
      wait_accept(ri, "rand");
      wait_idle("rand", 200);
      check("rand_result", last_resp, {IDW'(ri), exp_prod(ra, rb), 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
